// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3, one input bit per clock.
// The control unit drives a 4-phase en/rdy handshake; the BCD result holds between conversions.
module bin_bcd_seq #(
  parameter int IN_W   = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [IN_W-1:0]       count,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  rdy,
  output logic                  busy
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [IN_W-1:0] bin_sr;
  logic [BW-1:0]   scratch;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   nxt;
  logic [CW-1:0]   cnt;

  // Add-3 on every digit in parallel, then shift the next binary MSB in
  always_comb begin
    adj = scratch;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    nxt = {adj[BW-2:0], bin_sr[IN_W-1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bin_sr  <= '0;
      scratch <= '0;
      cnt     <= '0;
      BCD     <= '0;
      rdy     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rdy  <= 1'b0;
          busy <= 1'b0;
          if (en) begin
            bin_sr  <= count;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= nxt;
          bin_sr  <= {bin_sr[IN_W-2:0], 1'b0};
          cnt     <= cnt + 1'b1;
          // Final iteration publishes the shifted value directly
          if (cnt == CW'(IN_W - 1)) begin
            BCD   <= nxt;
            busy  <= 1'b0;
            rdy   <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (!en) begin
            rdy   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
